if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 32-bit 5-stage pipeline, directly upstream of the ID stage.
- Owns the PC and the IF/ID pipeline register, and drives Instruction and Next_Address into ID.
- Consumes ID's hazard outputs (PCWrite, freeze) and branch-redirect outputs (PCSrc, Branch_Address).
- Fetches over a single-outstanding req/ready instruction-memory handshake. A 1-entry hold buffer absorbs responses that arrive while ID is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0) written into IF/ID on squash/reset.

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  reset; synchronous, active-low (0 = reset)
- PCWrite  input  1  from ID hazard unit; 0 = hold PC
- freeze  input  1  from ID hazard unit; 1 = hold IF/ID register
- PCSrc  input  1  from ID; 1 = taken branch, redirect to Branch_Address
- Branch_Address  input  32  branch target from ID
- imem_req  output  1  fetch request (combinational from state)
- imem_addr  output  32  fetch address, word aligned
- imem_ready  input  1  memory response valid this cycle; may be high the same cycle as req
- imem_rdata  input  32  instruction word, valid when imem_ready=1
- Instruction  output  32  IF/ID register: instruction to ID
- Next_Address  output  32  IF/ID register: PC+4 of that instruction
- if_valid  output  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (rst=0 at posedge):
  - PC <= RESET_PC; state <= S_FETCH; hold buffer cleared.
  - Instruction <= NOP_INSTR; Next_Address <= 0; if_valid <= 0.
  - imem_req is forced 0 while rst=0.
  - Reset in any state, including with a request outstanding, aborts the request; memory is reset alongside.
- advance = PCWrite & ~freeze. redirect = PCSrc.
- Arithmetic:
  - PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
  - Branch_Address is used as given; bits [1:0] are ignored, and imem_addr[1:0] is always 0.
- States:
  - S_FETCH:
    - Outputs: imem_req=1, imem_addr=PC.
    - redirect=1: PC <= Branch_Address; IF/ID <= bubble. If imem_ready=1, discard the response and stay in S_FETCH; otherwise go to S_DRAIN.
    - imem_ready=1 & advance=1: IF/ID <= {imem_rdata, PC+4, valid=1}; PC <= PC+4; stay in S_FETCH. This gives 1 instruction/cycle with zero-wait memory.
    - imem_ready=1 & advance=0: hold <= {imem_rdata, PC+4}; PC unchanged; go to S_HOLD.
    - imem_ready=0: all registers hold. If advance=1, IF/ID <= bubble (ID consumed its instruction, nothing new). imem_addr must stay stable.
  - S_HOLD:
    - Outputs: imem_req=0.
    - redirect=1: drop hold; PC <= Branch_Address; IF/ID <= bubble; go to S_FETCH.
    - advance=1: IF/ID <= hold contents, valid=1; PC <= PC+4; go to S_FETCH.
    - Else: stay.
  - S_DRAIN:
    - Outputs: imem_req=1, imem_addr=old PC, latched separately as drain_addr.
    - imem_ready=1: discard the response; go to S_FETCH, which then fetches the redirected PC.
    - IF/ID shows a bubble whenever advance=1.
    - A further redirect updates PC only.
- Priority: reset > redirect > stall (advance=0) > normal fetch.
- If freeze=1 and redirect=1 together, the redirect wins: IF/ID is squashed to a bubble and PC is updated.
- PC never changes while PCWrite=0, except on redirect or reset.
- IF/ID never changes while freeze=1, except on redirect or reset.
- Exactly one request is outstanding at any time. A response is never accepted into IF/ID after a redirect that occurred before it arrived.

Decomposition:
- Shared package holds the state encoding (S_FETCH, S_HOLD, S_DRAIN, 2-bit), NOP_INSTR, and the PC increment constant 4.
- One natural sub-module: if_id_reg, the IF/ID register with load/squash/hold controls and sync active-low reset. The fetch FSM, PC and hold buffer stay in if_stage.

Test Plan:
- Zero-wait memory (ready tied 1), imem_rdata = address-derived pattern, rst released at cycle 2 → imem_addr runs 0,4,8,C; Instruction updates every cycle; Next_Address = addr+4; if_valid=1 from the first fetch.
- 2-cycle memory latency → each fetch holds imem_addr stable for 2 cycles; IF/ID shows a bubble (if_valid=0) in the wait cycle when advance=1.
- freeze=1 & PCWrite=0 for 3 cycles while a response arrives at PC=0x10 → IF/ID and PC hold; word goes to S_HOLD; after release Instruction=word@0x10, Next_Address=0x14; no refetch of 0x10.
- PCSrc=1, Branch_Address=0x40 in S_FETCH with ready=1 → next Instruction=NOP, if_valid=0; next imem_addr=0x40; the 0x40 word reaches IF/ID one cycle later.
- PCSrc=1 while a fetch of 0x20 is pending (ready=0) → S_DRAIN keeps addr 0x20 until ready; that response is discarded; the next request is 0x80 (target); 0x20 word never appears on Instruction.
- rst=0 asserted mid-S_HOLD and PC=0xFFFF_FFFC wrap case → after reset PC=0, if_valid=0, state S_FETCH; separately, a fetch at 0xFFFF_FFFC gives Next_Address=0 and next imem_addr=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_pkg
// Brief    : Shared state encoding and constants for the instruction-fetch stage
// Revision : 1.0  initial release
// ============================================================================
package if_stage_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // sll $0,$0,0 used as the pipeline bubble
    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] C_PC_INC    = 32'd4;

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_if
// Brief    : Single-outstanding req/ready instruction-memory fetch bus
// Revision : 1.0  initial release
// ============================================================================
interface if_stage_if ();
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with squash (priority) / load / hold
// Revision : 1.0  initial release
// ============================================================================
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  wire         clk,
    input  wire         rst,
    input  wire         i_load,
    input  wire         i_squash,
    input  wire  [31:0] i_instr,
    input  wire  [31:0] i_next_addr,
    output logic [31:0] o_instr,
    output logic [31:0] o_next_addr,
    output logic        o_valid
);
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (i_squash) begin
            instr_d = NOP_INSTR;
            npc_d   = '0;
            valid_d = 1'b0;
        end else if (i_load) begin
            instr_d = i_instr;
            npc_d   = i_next_addr;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q <= NOP_INSTR;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign o_instr     = instr_q;
    assign o_next_addr = npc_q;
    assign o_valid     = valid_q;
endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch stage: PC, fetch FSM, 1-entry hold buffer, IF/ID
// Revision : 1.0  initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  wire                clk,
    input  wire                rst,
    input  wire                PCWrite,
    input  wire                freeze,
    input  wire                PCSrc,
    input  wire  [31:0]        Branch_Address,
    if_stage_if.master         imem,
    output logic [31:0]        Instruction,
    output logic [31:0]        Next_Address,
    output logic               if_valid
);
    localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_npc_q, hold_npc_d;
    logic [31:0] drain_addr_q, drain_addr_d;

    logic        advance;
    logic        redirect;
    logic [31:0] pc_plus4;
    logic [31:0] branch_pc;
    logic        ifid_load;
    logic        ifid_squash;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;

    assign advance   = PCWrite & ~freeze;
    assign redirect  = PCSrc;
    assign pc_plus4  = pc_q + C_PC_INC;
    assign branch_pc = Branch_Address & C_ALIGN_MASK;

    assign imem.req  = rst && (state_q != S_HOLD);
    // While draining, the bus must keep presenting the address of the abandoned fetch
    assign imem.addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        hold_npc_d   = hold_npc_q;
        drain_addr_d = drain_addr_q;
        ifid_load    = 1'b0;
        ifid_squash  = 1'b0;
        ifid_instr   = imem.rdata;
        ifid_npc     = pc_plus4;
        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    pc_d        = branch_pc;
                    ifid_squash = 1'b1;
                    if (!imem.ready) begin
                        drain_addr_d = pc_q;
                        state_d      = S_DRAIN;
                    end
                end else if (imem.ready) begin
                    if (advance) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_plus4;
                    end else begin
                        hold_instr_d = imem.rdata;
                        hold_npc_d   = pc_plus4;
                        state_d      = S_HOLD;
                    end
                end else if (advance) begin
                    ifid_squash = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d        = branch_pc;
                    ifid_squash = 1'b1;
                    state_d     = S_FETCH;
                end else if (advance) begin
                    ifid_load  = 1'b1;
                    ifid_instr = hold_instr_q;
                    ifid_npc   = hold_npc_q;
                    pc_d       = pc_plus4;
                    state_d    = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    pc_d = branch_pc;
                end
                if (advance) begin
                    ifid_squash = 1'b1;
                end
                if (imem.ready) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC & C_ALIGN_MASK;
            hold_instr_q <= '0;
            hold_npc_q   <= '0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            hold_npc_q   <= hold_npc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .i_load      (ifid_load),
        .i_squash    (ifid_squash),
        .i_instr     (ifid_instr),
        .i_next_addr (ifid_npc),
        .o_instr     (Instruction),
        .o_next_addr (Next_Address),
        .o_valid     (if_valid)
    );
endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage with a latency-programmable memory
// Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;
    import if_stage_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCWrite = 1'b0;
    logic        freeze = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] Branch_Address = '0;
    logic [31:0] Instruction;
    logic [31:0] Next_Address;
    logic        if_valid;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PCWrite        (PCWrite),
        .freeze         (freeze),
        .PCSrc          (PCSrc),
        .Branch_Address (Branch_Address),
        .imem           (bus),
        .Instruction    (Instruction),
        .Next_Address   (Next_Address),
        .if_valid       (if_valid)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_lat  = 1;
    int          mcnt     = 0;
    logic [31:0] exp_instr = 32'h0;
    logic [31:0] exp_npc   = 32'h0;
    logic        exp_valid = 1'b0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_0001;
    endfunction

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.instr = word(a);
        e.npc   = a + 32'd4;
        sb.push_back(e);
    endtask

    // One clock: drive inputs and memory response, clock, then check IF/ID
    task automatic cycle(input logic pcw, input logic frz, input logic src,
                         input logic [31:0] ba);
        logic rst_hi;
        logic adv;
        exp_t e;
        PCWrite = pcw; freeze = frz; PCSrc = src; Branch_Address = ba;
        #1;
        if (bus.req && mcnt >= mem_lat - 1) begin
            bus.ready = 1'b1; bus.rdata = word(bus.addr); mcnt = 0;
        end else if (bus.req) begin
            bus.ready = 1'b0; bus.rdata = 32'hBAD0_BAD0; mcnt++;
        end else begin
            bus.ready = 1'b0; bus.rdata = 32'hBAD0_BAD0; mcnt = 0;
        end
        rst_hi = rst;
        adv    = pcw & ~frz;
        @(posedge clk);
        @(negedge clk);
        if (!rst_hi) begin
            exp_valid = 1'b0; exp_instr = C_NOP_INSTR; mcnt = 0;
        end else if (src) begin
            n_checks++;
            if (if_valid !== 1'b0 || Instruction !== C_NOP_INSTR) begin
                n_fail++;
                $display("FAIL squash: valid=%0b instr=%h, required valid=0 instr=%h",
                         if_valid, Instruction, C_NOP_INSTR);
            end
            exp_valid = 1'b0; exp_instr = C_NOP_INSTR;
        end else if (adv) begin
            n_checks++;
            if (if_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_instr: instr=%h npc=%h, required none",
                             Instruction, Next_Address);
                end else begin
                    e = sb.pop_front();
                    if (Instruction !== e.instr || Next_Address !== e.npc) begin
                        n_fail++;
                        $display("FAIL ifid_data: instr=%h npc=%h, required instr=%h npc=%h",
                                 Instruction, Next_Address, e.instr, e.npc);
                    end
                    exp_valid = 1'b1; exp_instr = e.instr; exp_npc = e.npc;
                end
            end else begin
                if (if_valid !== 1'b0 || Instruction !== C_NOP_INSTR) begin
                    n_fail++;
                    $display("FAIL bubble: valid=%b instr=%h, required valid=0 instr=%h",
                             if_valid, Instruction, C_NOP_INSTR);
                end
                exp_valid = 1'b0; exp_instr = C_NOP_INSTR;
            end
        end else begin
            n_checks++;
            if (if_valid !== exp_valid || Instruction !== exp_instr ||
                (exp_valid && Next_Address !== exp_npc)) begin
                n_fail++;
                $display("FAIL ifid_hold: valid=%b instr=%h npc=%h, required valid=%b instr=%h npc=%h",
                         if_valid, Instruction, Next_Address, exp_valid, exp_instr, exp_npc);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (if_valid !== 1'b0 || Instruction !== C_NOP_INSTR || Next_Address !== 32'h0 ||
            bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b instr=%h npc=%h req=%b, required 0/%h/0/0",
                     if_valid, Instruction, Next_Address, bus.req, C_NOP_INSTR);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_release: req=%b addr=%h, required req=1 addr=00000000",
                     bus.req, bus.addr);
        end
    endtask

    task automatic test_zero_wait();
        mem_lat = 1;
        for (int i = 0; i < 4; i++) push(32'(4 * i));
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.addr !== 32'(4 * i) || bus.req !== 1'b1) begin
                n_fail++;
                $display("FAIL zw_addr: addr=%h req=%b, required addr=%h req=1",
                         bus.addr, bus.req, 32'(4 * i));
            end
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL zw_drain: pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_freeze_hold();
        mem_lat = 1;
        push(32'h10);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (bus.req !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_req: req=%b, required 0", bus.req);
            end
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h14 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL hold_release: req=%b addr=%h pending=%0d, required req=1 addr=00000014 pending=0",
                     bus.req, bus.addr, sb.size());
        end
    endtask

    task automatic test_latency();
        mem_lat = 2;
        for (int i = 0; i < 3; i++) push(32'h14 + 32'(4 * i));
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (bus.addr !== 32'h14 + 32'(4 * (k / 2))) begin
                n_fail++;
                $display("FAIL lat_addr: addr=%h, required %h", bus.addr, 32'h14 + 32'(4 * (k / 2)));
            end
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            if (k % 2 == 0) begin
                n_checks++;
                if (if_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lat_bubble: valid=%b, required 0", if_valid);
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL lat_drain: pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_branch_ready();
        mem_lat = 1;
        cycle(1'b1, 1'b0, 1'b1, 32'h40);
        n_checks++;
        if (bus.addr !== 32'h40) begin
            n_fail++;
            $display("FAIL br_addr: addr=%h, required 00000040", bus.addr);
        end
        push(32'h40);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        push(32'h44);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        // freeze together with redirect: redirect must win
        cycle(1'b0, 1'b1, 1'b1, 32'h60);
        n_checks++;
        if (bus.addr !== 32'h60 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL br_freeze: addr=%h pending=%0d, required addr=00000060 pending=0",
                     bus.addr, sb.size());
        end
    endtask

    task automatic test_branch_pending();
        mem_lat = 1;
        cycle(1'b1, 1'b0, 1'b1, 32'h20);
        mem_lat = 3;
        cycle(1'b1, 1'b0, 1'b1, 32'h70);
        n_checks++;
        if (bus.addr !== 32'h20 || bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_addr0: addr=%h req=%b, required addr=00000020 req=1", bus.addr, bus.req);
        end
        cycle(1'b1, 1'b0, 1'b1, 32'h80);
        n_checks++;
        if (bus.addr !== 32'h20) begin
            n_fail++;
            $display("FAIL drain_addr1: addr=%h, required 00000020", bus.addr);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.addr !== 32'h80 || bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_target: addr=%h req=%b, required addr=00000080 req=1", bus.addr, bus.req);
        end
        push(32'h80);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_sb: pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_wrap();
        mem_lat = 1;
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        n_checks++;
        if (bus.addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_align: addr=%h, required fffffffc", bus.addr);
        end
        push(32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (Next_Address !== 32'h0 || bus.addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_pc: npc=%h addr=%h, required npc=00000000 addr=00000000",
                     Next_Address, bus.addr);
        end
        push(32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_hold();
        mem_lat = 1;
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL rhold_enter: req=%b, required 0", bus.req);
        end
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (if_valid !== 1'b0 || Instruction !== C_NOP_INSTR || Next_Address !== 32'h0 ||
            bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL rhold_reset: valid=%b instr=%h npc=%h req=%b, required 0/%h/0/0",
                     if_valid, Instruction, Next_Address, bus.req, C_NOP_INSTR);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rhold_release: req=%b addr=%h, required req=1 addr=00000000",
                     bus.req, bus.addr);
        end
        push(32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rhold_sb: pending=%0d, required 0", sb.size());
        end
    endtask

    initial begin
        bus.ready = 1'b0;
        bus.rdata = '0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_freeze_hold();
        test_latency();
        test_branch_ready();
        test_branch_pending();
        test_wrap();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
